// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack and its command front-end:
// opcodes, controller FSM encoding and default sizes.
package lifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RSP   = 2'd3
  } state_t;

endpackage

// File: rtl/lifo_cmd_ctrl_if.sv
// Command and response valid/ready streams of the LIFO command controller.
// The master side issues commands and consumes responses.
interface lifo_cmd_ctrl_if #(
  parameter int DATA_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/lifo_cmd_ctrl.sv
// Command front-end for lifo_stack: one command in flight, one response each.
// Optional macro LIFO_CTRL_ERR_CNT_EN adds a saturating illegal-command counter (err_count).
module lifo_cmd_ctrl
  import lifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = 4
`ifdef LIFO_CTRL_ERR_CNT_EN
  ,
  parameter int ERR_W  = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  lifo_cmd_ctrl_if.slave    bus,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_data_in,
  input  logic [DATA_W-1:0] stk_data_out,
  output logic [CNT_W-1:0]  level
`ifdef LIFO_CTRL_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0]  err_count
`endif
);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              legal;
  logic              op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              cmd_ready_c;
  logic              rsp_valid_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The stack flags lag by a cycle, so legality is judged against our own level.
  always_comb begin
    next_state  = state;
    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    accept      = 1'b0;
    legal       = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        accept      = bus.cmd_valid;
        legal       = (bus.cmd_op == OP_PUSH) ? (level < CNT_W'(DEPTH))
                                              : (level != '0);
        if (accept) begin
          next_state = legal ? ST_ISSUE : ST_RSP;
        end
      end
      ST_ISSUE: begin
        stk_push   = (op_q == OP_PUSH);
        stk_pop    = (op_q == OP_POP);
        next_state = (op_q == OP_PUSH) ? ST_RSP : ST_WAIT;
      end
      ST_WAIT: begin
        next_state = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Response data is zeroed on accept and only overwritten by a pop's stack output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_PUSH;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      level      <= '0;
    end else begin
      if (accept) begin
        op_q       <= bus.cmd_op;
        data_q     <= bus.cmd_data;
        rsp_data_q <= '0;
        rsp_err_q  <= ~legal;
      end
      if (state == ST_ISSUE) begin
        level <= (op_q == OP_PUSH) ? level + CNT_W'(1) : level - CNT_W'(1);
      end
      if (state == ST_WAIT) begin
        rsp_data_q <= stk_data_out;
      end
    end
  end

`ifdef LIFO_CTRL_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (accept && !legal && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end
`endif

  assign stk_data_in   = data_q;
  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lifo_cmd_ctrl.sv
// Self-checking bench for lifo_cmd_ctrl: directed commands against a queue-based model.
// Build with LIFO_CTRL_ERR_CNT_EN defined to also exercise err_count (ERR_W=2).
module tb_lifo_cmd_ctrl;
  import lifo_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
`ifdef LIFO_CTRL_ERR_CNT_EN
  localparam int ERR_W  = 2;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_data_in;
  logic [DATA_W-1:0] stk_data_out;
  logic [CNT_W-1:0]  level;
`ifdef LIFO_CTRL_ERR_CNT_EN
  logic [ERR_W-1:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;

  lifo_cmd_ctrl_if #(.DATA_W(DATA_W)) bus ();

  lifo_cmd_ctrl #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
`ifdef LIFO_CTRL_ERR_CNT_EN
    ,
    .ERR_W (ERR_W)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .stk_push    (stk_push),
    .stk_pop     (stk_pop),
    .stk_data_in (stk_data_in),
    .stk_data_out(stk_data_out),
    .level       (level)
`ifdef LIFO_CTRL_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for lifo_stack: registered data_out updated by a pop strobe.
  logic [DATA_W-1:0] mem [DEPTH];
  int sp = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
      stk_data_out <= '0;
    end else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_data_in;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_data_out <= mem[sp-1];
      sp <= sp - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Model: a queue holding stack contents plus the one command in flight.
  logic [DATA_W-1:0] mstack[$];
  int   edge_cnt = 0;
  bit   pend = 0;
  int   acc_edge = 0;
  int   lat_edges = 0;
  bit   m_legal = 0;
  bit   m_op = 0;
  logic [DATA_W-1:0] m_push_data = '0;
  logic [DATA_W-1:0] exp_data = '0;
  bit   exp_err = 0;
  int   m_level = 0;
  int   m_level_next = 0;
  int   m_err = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mstack.delete();
      pend = 0;
      m_level = 0;
      m_err = 0;
    end else begin
      edge_cnt++;
      if (pend && m_legal && edge_cnt == acc_edge + 1) m_level = m_level_next;
      if (pend && bus.rsp_valid && bus.rsp_ready) pend = 0;
      if (bus.cmd_valid && bus.cmd_ready) begin
        pend = 1;
        acc_edge = edge_cnt;
        m_op = bus.cmd_op;
        m_push_data = bus.cmd_data;
        exp_data = '0;
        if (bus.cmd_op == OP_PUSH) begin
          m_legal = mstack.size() < DEPTH;
          if (m_legal) mstack.push_back(bus.cmd_data);
          lat_edges = m_legal ? 1 : 0;
        end else begin
          m_legal = mstack.size() > 0;
          if (m_legal) exp_data = mstack.pop_back();
          lat_edges = m_legal ? 2 : 0;
        end
        exp_err = !m_legal;
        m_level_next = mstack.size();
`ifdef LIFO_CTRL_ERR_CNT_EN
        if (!m_legal && m_err < (1 << ERR_W) - 1) m_err++;
`endif
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit exp_valid;
    bit exp_strobe;
    exp_valid  = pend && (edge_cnt >= acc_edge + lat_edges);
    exp_strobe = pend && m_legal && (edge_cnt == acc_edge);
    checkOutput("cmd_ready", bus.cmd_ready, !pend);
    checkOutput("rsp_valid", bus.rsp_valid, exp_valid);
    if (exp_valid) begin
      checkOutput("rsp_data", bus.rsp_data, exp_data);
      checkOutput("rsp_err", bus.rsp_err, exp_err);
    end
    checkOutput("stk_push", stk_push, exp_strobe && m_op == OP_PUSH);
    checkOutput("stk_pop", stk_pop, exp_strobe && m_op == OP_POP);
    if (exp_strobe && m_op == OP_PUSH) checkOutput("stk_data_in", stk_data_in, m_push_data);
    checkOutput("level", level, m_level);
`ifdef LIFO_CTRL_ERR_CNT_EN
    checkOutput("err_count", err_count, m_err);
`endif
  end

  task automatic applyStimulus(input logic op, input logic [DATA_W-1:0] data, input int hold,
                               output logic [DATA_W-1:0] rdata, output logic rerr,
                               output int lat);
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) timeoutFail("accept");
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) timeoutFail("rsp_valid");
    repeat (hold) @(negedge clk);
    rdata = bus.rsp_data;
    rerr  = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic doOp(input string name, input logic op, input logic [DATA_W-1:0] data,
                      input int hold, input logic [DATA_W-1:0] edata, input logic eerr,
                      input int elat);
    logic [DATA_W-1:0] rdata;
    logic rerr;
    int lat;
    applyStimulus(op, data, hold, rdata, rerr, lat);
    checkOutput({name, "_data"}, rdata, edata);
    checkOutput({name, "_err"}, rerr, eerr);
    checkOutput({name, "_lat"}, lat, elat);
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rsp_data", bus.rsp_data, 0);
    checkOutput("rst_stk_data_in", stk_data_in, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", bus.cmd_ready, 1);

    doOp("push11", OP_PUSH, 8'h11, 0, 8'h00, 1'b0, 2);
    doOp("push22", OP_PUSH, 8'h22, 0, 8'h00, 1'b0, 2);
    doOp("push33", OP_PUSH, 8'h33, 0, 8'h00, 1'b0, 2);
    checkOutput("level3", level, 3);
    doOp("pop33", OP_POP, 8'h00, 0, 8'h33, 1'b0, 3);
    doOp("pop22", OP_POP, 8'h00, 0, 8'h22, 1'b0, 3);
    doOp("pop11", OP_POP, 8'h00, 0, 8'h11, 1'b0, 3);
    checkOutput("level0", level, 0);

    doOp("pop_empty", OP_POP, 8'h00, 0, 8'h00, 1'b1, 1);
    checkOutput("level_after_underflow", level, 0);

    for (int i = 0; i < DEPTH; i++) begin
      doOp("fill", OP_PUSH, 8'hA0 + 8'(i), 0, 8'h00, 1'b0, 2);
    end
    doOp("push_full", OP_PUSH, 8'hFF, 0, 8'h00, 1'b1, 1);
    checkOutput("level_full", level, 8);
    doOp("popA7", OP_POP, 8'h00, 0, 8'hA7, 1'b0, 3);

    doOp("push5A", OP_PUSH, 8'h5A, 0, 8'h00, 1'b0, 2);
    doOp("pop5A_hold", OP_POP, 8'h00, 5, 8'h5A, 1'b0, 3);
    checkOutput("ready_after_release", bus.cmd_ready, 1);

    // Pop then reset while the controller waits on stack data.
    doOp("push3C", OP_PUSH, 8'h3C, 0, 8'h00, 1'b0, 2);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_POP;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) timeoutFail("accept_rst_pop");
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("midrst_level", level, 0);
    checkOutput("midrst_stk_pop", stk_pop, 0);
    checkOutput("midrst_rsp_err", bus.rsp_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("no_rsp_after_rst", bus.rsp_valid, 0);
    doOp("push77", OP_PUSH, 8'h77, 0, 8'h00, 1'b0, 2);
    doOp("pop77", OP_POP, 8'h00, 0, 8'h77, 1'b0, 3);

`ifdef LIFO_CTRL_ERR_CNT_EN
    begin
      int exp_cnt [5] = '{1, 2, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
        doOp("errcnt_pop", OP_POP, 8'h00, 0, 8'h00, 1'b1, 1);
        checkOutput("err_count_lit", err_count, exp_cnt[i]);
      end
    end
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lifo_cmd_ctrl.md
Name: lifo_cmd_ctrl

Overview:
Command front-end for the 8-deep LIFO stack (lifo_stack). It accepts push/pop commands on a valid/ready stream and converts them into single-cycle stk_push/stk_pop strobes. It keeps its own occupancy count, because the stack's empty/full flags lag top by a cycle. Every command returns exactly one response on a valid/ready stream: pop data, or an error flag for overflow/underflow.

Parameters:
DATA_W, 8, command/response/stack data width
DEPTH, 8, stack capacity; must equal the stack's STACK_SIZE
CNT_W, 4, occupancy counter width; must hold 0..DEPTH
ERR_W, 8, error counter width (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  1  0 = push, 1 = pop
cmd_data  in  DATA_W  push payload; ignored for pop
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_data  out  DATA_W  popped value; 0 for push or error
rsp_err  out  1  1 = push on full or pop on empty
stk_push  out  1  push strobe to stack
stk_pop  out  1  pop strobe to stack
stk_data_in  out  DATA_W  data to stack
stk_data_out  in  DATA_W  stack registered output
level  out  CNT_W  current occupancy 0..DEPTH

Behaviour:
- Reset (async): state=IDLE, level=0, stk_push=0, stk_pop=0, stk_data_in=0, rsp_valid=0, rsp_data=0, rsp_err=0. cmd_ready=1 once reset deasserts.
- The stack shares this reset, so both sides return to empty together when reset is asserted mid-operation. Any in-flight command and pending response are discarded.
- FSM states: IDLE, ISSUE, WAIT, RSP.
- cmd_ready = (state==IDLE). Accept occurs on cmd_valid && cmd_ready in cycle T; op and data are registered at T.
- IDLE, accept, legal command (push with level<DEPTH, or pop with level>0): go to ISSUE.
- IDLE, accept, illegal command (push with level==DEPTH, or pop with level==0): no strobe, level unchanged. Go to RSP with rsp_err=1, rsp_data=0; rsp_valid rises at T+1.
- ISSUE (T+1): exactly one of stk_push or stk_pop is high, for this cycle only. stk_data_in=cmd_data for push. Level changes by ±1 at the end of this cycle.
  - Push: go to RSP; rsp_valid at T+2, rsp_err=0, rsp_data=0.
  - Pop: go to WAIT.
- WAIT (T+2): stack data_out now holds the popped value. Capture stk_data_out into rsp_data. Go to RSP; rsp_valid at T+3, rsp_err=0.
- RSP: rsp_valid, rsp_data and rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE. The next accept can occur in the following cycle.
- stk_push and stk_pop are never high together, and never high outside ISSUE.
- level never exceeds DEPTH and never underflows.
- Throughput is one command in flight. Best case is one push per 3 cycles with rsp_ready tied high.

Optional Feature:
LIFO_CTRL_ERR_CNT_EN
- Defined: adds output port err_count [ERR_W-1:0]. It increments on each accepted illegal command and saturates at all-ones. Reset clears it to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package lifo_pkg: OP_PUSH=1'b0, OP_POP=1'b1; FSM state encoding (2-bit IDLE/ISSUE/WAIT/RSP); default DATA_W and DEPTH, shared with the stack.
- Single module; no sub-module needed. The occupancy counter is a few lines and stays inline.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33, then pop ×3 -> rsp_data 0x33, 0x22, 0x11 with rsp_err=0; level 3→0; each pop rsp_valid at T+3 after accept.
- Pop with level=0 -> rsp_valid at T+1, rsp_err=1, rsp_data=0; no stk_pop pulse; level stays 0.
- Push 8 values 0xA0..0xA7, then a 9th push 0xFF -> 9th rsp_err=1, no stk_push, level=8. Next pop -> 0xA7.
- Hold rsp_ready=0 for 5 cycles after a pop of 0x5A -> rsp_valid/rsp_data stable at 0x5A, cmd_ready=0 throughout. Release -> cmd_ready=1 the next cycle.
- Assert reset during WAIT of a pop -> all outputs return to reset values immediately, level=0, no response issued. A following push 0x77 then pop -> 0x77.
- With LIFO_CTRL_ERR_CNT_EN and ERR_W=2: issue 5 pops on empty -> err_count 1, 2, 3, 3, 3.
